// File: rtl/uart_rx_param_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_param_pkg
// Shared UART definitions for the receiver and the transmitter: the
// oversampling factor, the parity_mode encodings, the receiver FSM state
// encodings and the baud divisor function used to build the divisor table.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_param_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 14;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11   // decoded as "no parity"
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_e;

    // round(clk_hz / (baud * 16)) for baud_select codes 0..7.
    // Adding half the denominator before dividing gives round-to-nearest.
    function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input int sel);
        int baud;
        case (sel)
            0:       baud = 300;
            1:       baud = 1200;
            2:       baud = 4800;
            3:       baud = 9600;
            4:       baud = 19200;
            5:       baud = 38400;
            6:       baud = 57600;
            default: baud = 115200;
        endcase
        return DIV_W'((clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// 16x oversampling tick generator. A 14-bit down-counter reloads from a
// constant divisor table, so no run-time divider is built.
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   baud_select : divisor table index (300 .. 115200 baud)
//   restart     : reload the counter so the next tick is a full DIV away
//   tick        : one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_rx_param_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       restart,
    output logic       tick
);

    localparam logic [DIV_W-1:0] DIV_TAB [8] = '{
        baud_div(CLK_HZ, 0), baud_div(CLK_HZ, 1), baud_div(CLK_HZ, 2), baud_div(CLK_HZ, 3),
        baud_div(CLK_HZ, 4), baud_div(CLK_HZ, 5), baud_div(CLK_HZ, 6), baud_div(CLK_HZ, 7)
    };

    logic [DIV_W-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= DIV_TAB[baud_select] - DIV_W'(1);
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: 5..9 data bits, run-time parity (none/even/odd),
// one or two stop bits, 2-flop input synchroniser, 3-sample majority vote,
// false-start rejection and break detection.
//   clk, reset    : system clock / synchronous active-high reset
//   baud_select   : 300 .. 115200 baud, latched at the start edge
//   RX_EN         : receiver enable; low abandons any frame in progress
//   RxD           : asynchronous serial line, idle high
//   parity_mode   : 00 none, 01 even, 10 odd, 11 none (latched at start)
//   stop2         : check a second stop bit (latched at start)
//   Rx_DATA       : received word, first bit received in the LSB
//   Rx_VALID      : one-cycle frame-complete strobe
//   Rx_PERROR     : parity mismatch on the last frame
//   Rx_FERROR     : a stop bit sampled low on the last frame
//   Rx_BREAK      : last frame was all zero including stop bit 1
//   Rx_BUSY       : FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        baud_select,
    input  logic              RX_EN,
    input  logic              RxD,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_PERROR,
    output logic              Rx_FERROR,
    output logic              Rx_BREAK,
    output logic              Rx_BUSY
);

    rx_state_e         state, state_nxt;
    logic [1:0]        sync;
    logic              rxd_s;
    logic              tick;

    // Per-frame configuration captured at the start edge.
    logic [2:0]        baud_q;
    parity_mode_e      par_q;
    logic              stop2_q;

    logic [3:0]        sc;
    logic [3:0]        sc_nxt;
    logic [1:0]        votes;      // samples at sc = 7 and 8
    logic [3:0]        bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              perr_q;
    logic              stop1_bit;

    logic              maj, decide, wrap, par_en, par_exp;
    logic              restart, shift_en, latch_par, latch_stop1;
    logic              commit, commit_ferr, commit_brk;

    assign rxd_s   = sync[1];
    assign sc_nxt  = sc + 4'd1;
    assign decide  = tick && (sc_nxt == 4'd9);
    assign wrap    = tick && (sc == 4'd15);
    assign maj     = (votes[0] & votes[1]) | (votes[0] & rxd_s) | (votes[1] & rxd_s);
    assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign par_exp = (^shreg) ^ (par_q == PAR_ODD);
    assign Rx_BUSY = (state != ST_IDLE);

    // The divider must see the new baud_select on the very cycle it restarts.
    uart_baud_gen #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk         (clk),
        .reset       (reset),
        .baud_select (restart ? baud_select : baud_q),
        .restart     (restart),
        .tick        (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        restart     = 1'b0;
        shift_en    = 1'b0;
        latch_par   = 1'b0;
        latch_stop1 = 1'b0;
        commit      = 1'b0;
        commit_ferr = 1'b0;
        commit_brk  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (RX_EN && !rxd_s) begin
                    restart   = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (decide && maj)  state_nxt = ST_IDLE;   // false start
                else if (wrap)      state_nxt = ST_DATA;
            end
            ST_DATA: begin
                shift_en = decide;
                if (wrap && bitcnt == 4'(DATA_W))
                    state_nxt = par_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                latch_par = decide;
                if (wrap) state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (decide && !stop2_q) begin
                    commit      = 1'b1;
                    commit_ferr = !maj;
                    commit_brk  = (shreg == '0) && !(par_en && par_bit) && !maj;
                    state_nxt   = commit_brk ? ST_WAIT_IDLE : ST_IDLE;
                end else begin
                    latch_stop1 = decide;
                    if (wrap) state_nxt = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (decide) begin
                    commit      = 1'b1;
                    commit_ferr = !stop1_bit || !maj;
                    commit_brk  = (shreg == '0) && !(par_en && par_bit) && !stop1_bit;
                    state_nxt   = commit_brk ? ST_WAIT_IDLE : ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxd_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A disable abandons the frame, except that a commit already decided
        // this cycle is allowed to complete.
        if (!RX_EN && !commit) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift register is cleared too, so a break check never
            // depends on bits left over from before reset.
            sync      <= 2'b11;
            baud_q    <= '0;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            sc        <= '0;
            votes     <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            perr_q    <= 1'b0;
            stop1_bit <= 1'b1;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            Rx_BREAK  <= 1'b0;
        end else begin
            sync <= {sync[0], RxD};

            if (restart) begin
                sc        <= '0;
                votes     <= '0;
                bitcnt    <= '0;
                par_bit   <= 1'b0;
                perr_q    <= 1'b0;
                stop1_bit <= 1'b1;
                baud_q    <= baud_select;
                par_q     <= parity_mode_e'(parity_mode);
                stop2_q   <= stop2;
            end else if (tick) begin
                sc <= sc_nxt;
                if (sc_nxt == 4'd7) votes[0] <= rxd_s;
                if (sc_nxt == 4'd8) votes[1] <= rxd_s;
            end

            if (shift_en) begin
                shreg  <= {maj, shreg[DATA_W-1:1]};
                bitcnt <= bitcnt + 4'd1;
            end

            if (latch_par) begin
                par_bit <= maj;
                perr_q  <= maj ^ par_exp;
            end

            if (latch_stop1) stop1_bit <= maj;

            Rx_VALID <= commit;
            if (commit) begin
                Rx_DATA   <= shreg;
                Rx_PERROR <= par_en && perr_q;
                Rx_FERROR <= commit_ferr;
                Rx_BREAK  <= commit_brk;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param at 115200 baud / 50 MHz (432 clocks per
// bit). An 8-bit instance runs a table of frames plus break, glitch and
// enable-drop sequences; a 7-bit instance covers odd parity with two stop
// bits and configuration latching.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int BIT = 432;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset;
    logic [2:0] baud;
    logic       en8, rxd8, s2_8;
    logic [1:0] pm8;
    logic [7:0] d8;
    logic       v8, pe8, fe8, br8, bz8;
    logic       en7, rxd7, s2_7;
    logic [1:0] pm7;
    logic [6:0] d7;
    logic       v7, pe7, fe7, br7, bz7;

    uart_rx_param #(.DATA_W(8), .CLK_HZ(50_000_000)) dut8 (
        .clk(clk), .reset(reset), .baud_select(baud), .RX_EN(en8), .RxD(rxd8),
        .parity_mode(pm8), .stop2(s2_8), .Rx_DATA(d8), .Rx_VALID(v8),
        .Rx_PERROR(pe8), .Rx_FERROR(fe8), .Rx_BREAK(br8), .Rx_BUSY(bz8)
    );

    uart_rx_param #(.DATA_W(7), .CLK_HZ(50_000_000)) dut7 (
        .clk(clk), .reset(reset), .baud_select(baud), .RX_EN(en7), .RxD(rxd7),
        .parity_mode(pm7), .stop2(s2_7), .Rx_DATA(d7), .Rx_VALID(v7),
        .Rx_PERROR(pe7), .Rx_FERROR(fe7), .Rx_BREAK(br7), .Rx_BUSY(bz7)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Strobe monitors: count rising edges and high cycles, capture flags.
    int         cyc = 0;
    int         p8 = 0, h8 = 0, p7 = 0, h7 = 0, vcyc8 = 0;
    logic       v8_prev = 1'b0, v7_prev = 1'b0;
    logic [7:0] c_d8 = '0;
    logic [6:0] c_d7 = '0;
    logic       c_pe8 = 0, c_fe8 = 0, c_br8 = 0, c_pe7 = 0, c_fe7 = 0, c_br7 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v8) begin
            h8++;
            if (!v8_prev) begin
                p8++;
                vcyc8 = cyc;
            end
            c_d8 = d8; c_pe8 = pe8; c_fe8 = fe8; c_br8 = br8;
        end
        if (v7) begin
            h7++;
            if (!v7_prev) p7++;
            c_d7 = d7; c_pe7 = pe7; c_fe7 = fe7; c_br7 = br7;
        end
        v8_prev = v8;
        v7_prev = v7;
    end

    int start_cyc = 0;

    task automatic hold(input bit sel7, input logic v, input int n);
        if (sel7) rxd7 = v;
        else      rxd8 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel7, input logic [7:0] data, input int nbits,
                              input logic use_par, input logic par_bit,
                              input logic stop_a, input logic has_b, input logic stop_b,
                              input int last_cyc, input int gap);
        start_cyc = cyc;
        hold(sel7, 1'b0, BIT);
        for (int i = 0; i < nbits; i++) hold(sel7, data[i], BIT);
        if (use_par) hold(sel7, par_bit, BIT);
        if (has_b) begin
            hold(sel7, stop_a, BIT);
            hold(sel7, stop_b, last_cyc);
        end else begin
            hold(sel7, stop_a, last_cyc);
        end
        hold(sel7, 1'b1, gap);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       s2;
        logic       use_par;
        logic       par_bit;
        logic       stop_a;
        logic       stop_b;
        int         last_cyc;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs [8];
    int   base, base_h, lat;

    initial begin
        // data  pm     s2    par? pbit  stopA stopB last gap  expect data perr ferr brk
        vecs[0] = '{8'h85, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BIT, 150, 8'h85, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h85, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, BIT, 150, 8'h85, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h85, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, BIT, 150, 8'h85, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 300, 0,   8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BIT, 150, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h07, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BIT, 150, 8'h07, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hF0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, BIT, 150, 8'hF0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'hE7, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, BIT, 150, 8'hE7, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; baud = 3'b111;
        en8 = 1'b1; rxd8 = 1'b1; pm8 = 2'b00; s2_8 = 1'b0;
        en7 = 1'b1; rxd7 = 1'b1; pm7 = 2'b10; s2_7 = 1'b1;

        // Reset state
        repeat (20) @(negedge clk);
        check("rst_data8",   32'(d8),  32'h0);
        check("rst_valid8",  32'(v8),  32'h0);
        check("rst_perr8",   32'(pe8), 32'h0);
        check("rst_ferr8",   32'(fe8), 32'h0);
        check("rst_break8",  32'(br8), 32'h0);
        check("rst_busy8",   32'(bz8), 32'h0);
        check("rst_data7",   32'(d7),  32'h0);
        check("rst_busy7",   32'(bz7), 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_busy8", 32'(bz8), 32'h0);

        // Table of frames on the 8-bit receiver
        for (int i = 0; i < 8; i++) begin
            pm8 = vecs[i].pmode;
            s2_8 = vecs[i].s2;
            base = p8;
            base_h = h8;
            send_frame(1'b0, vecs[i].data, 8, vecs[i].use_par, vecs[i].par_bit,
                       vecs[i].stop_a, vecs[i].s2, vecs[i].stop_b, vecs[i].last_cyc, vecs[i].gap);
            check($sformatf("vec%0d_strobes", i), 32'(p8 - base),   32'd1);
            check($sformatf("vec%0d_width", i),   32'(h8 - base_h), 32'd1);
            check($sformatf("vec%0d_data", i),    32'(c_d8),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d_perr", i),    32'(c_pe8), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i),    32'(c_fe8), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_break", i),   32'(c_br8), 32'(vecs[i].exp_brk));
            if (i == 0) begin
                // Start edge + 3 + ((11-1)*16 + 9) * 27 + 1 = +4567, +/- one tick
                lat = vcyc8 - start_cyc;
                check("vec0_latency", (lat >= 4540 && lat <= 4594) ? 32'd4567 : 32'(lat), 32'd4567);
            end
        end

        // Break: line low for 20 bit times
        pm8 = 2'b00; s2_8 = 1'b0;
        base = p8;
        hold(1'b0, 1'b0, 20 * BIT);
        check("brk_strobes", 32'(p8 - base), 32'd1);
        check("brk_data",    32'(c_d8),  32'h0);
        check("brk_break",   32'(c_br8), 32'h1);
        check("brk_ferr",    32'(c_fe8), 32'h1);
        check("brk_perr",    32'(c_pe8), 32'h0);
        check("brk_wait_busy", 32'(bz8), 32'h1);
        hold(1'b0, 1'b1, 4);
        check("brk_release_busy", 32'(bz8), 32'h0);
        hold(1'b0, 1'b1, BIT);
        check("brk_no_extra", 32'(p8 - base), 32'd1);
        send_frame(1'b0, 8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT, 150);
        check("brk_recover_strobes", 32'(p8 - base), 32'd2);
        check("brk_recover_data",    32'(c_d8),  32'h81);
        check("brk_recover_break",   32'(c_br8), 32'h0);
        check("brk_recover_ferr",    32'(c_fe8), 32'h0);

        // 100-cycle glitch: false start
        base = p8;
        hold(1'b0, 1'b0, 100);
        hold(1'b0, 1'b1, 600);
        check("glitch_strobes", 32'(p8 - base), 32'd0);
        check("glitch_busy",    32'(bz8), 32'h0);

        // RX_EN drop during D3 of 0x5A
        base = p8;
        start_cyc = cyc;
        hold(1'b0, 1'b0, BIT);
        hold(1'b0, 1'b0, BIT);   // D0
        hold(1'b0, 1'b1, BIT);   // D1
        hold(1'b0, 1'b0, BIT);   // D2
        hold(1'b0, 1'b1, 200);   // part of D3
        check("en_mid_busy", 32'(bz8), 32'h1);
        en8 = 1'b0;
        rxd8 = 1'b1;
        repeat (3) @(negedge clk);
        check("en_drop_busy", 32'(bz8), 32'h0);
        check("en_drop_held_data", 32'(d8), 32'h81);
        en8 = 1'b1;
        hold(1'b0, 1'b1, BIT);
        check("en_drop_strobes", 32'(p8 - base), 32'd0);
        send_frame(1'b0, 8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BIT, 150);
        check("en_after_strobes", 32'(p8 - base), 32'd1);
        check("en_after_data",    32'(c_d8),  32'hC3);
        check("en_after_ferr",    32'(c_fe8), 32'h0);

        // 7-bit, odd parity, two stop bits, second stop low
        base = p7;
        send_frame(1'b1, 8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BIT, 150);
        check("w7_strobes", 32'(p7 - base), 32'd1);
        check("w7_data",    32'(c_d7),  32'h55);
        check("w7_perr",    32'(c_pe7), 32'h0);
        check("w7_ferr",    32'(c_fe7), 32'h1);
        check("w7_break",   32'(c_br7), 32'h0);

        // Configuration changed mid-frame must not affect the frame in flight
        base = p7;
        fork
            begin
                repeat (3 * BIT) @(negedge clk);
                pm7 = 2'b00;
                s2_7 = 1'b0;
            end
        join_none
        send_frame(1'b1, 8'h2A, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, BIT, 150);
        check("w7_latch_strobes", 32'(p7 - base), 32'd1);
        check("w7_latch_data",    32'(c_d7),  32'h2A);
        check("w7_latch_perr",    32'(c_pe7), 32'h0);
        check("w7_latch_ferr",    32'(c_fe7), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
